muldiv_unit: RTL

- Parametrised, multi-cycle multiply/divide unit for the MIPS EX stage.
- Decodes R-type `funct` codes for mult/multu/div/divu/mfhi/mflo/mthi/mtlo, runs an iterative shift-add or restoring-divide datapath, and owns the architectural HI/LO registers.
- Stalls the pipeline while busy.
- Sits beside `ALU_Control`/ALU and is selected by the same `ALUOp_sig`/`funct` fields.

---
 rtl/mips_defs_pkg.sv | 44 ++++
 rtl/muldiv_unit_iter.sv | 63 ++++++
 rtl/muldiv_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_defs (package)
// Purpose  : Shared ALUOp / funct decode constants and muldiv FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mips_defs;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_recognised(input logic [5:0] f);
        return f inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                         FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    endfunction

    function automatic logic is_muldiv(input logic [5:0] f);
        return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    endfunction

    function automatic logic is_div_op(input logic [5:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : One-bit-per-cycle shift-add multiply / restoring divide core.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_last
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Upper half: partial product / remainder; lower half: multiplier / quotient.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;

    always_comb begin
        w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_mul_next = {w_add, r_acc[WIDTH-1:1]};
        w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_b});
        // When w_ge holds the difference is below r_b, so WIDTH bits suffice.
        w_diff     = w_shift[WIDTH-1:0] - r_b;
        w_div_next = {(w_ge ? w_diff : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_acc <= {{WIDTH{1'b0}}, i_a};
            r_b   <= i_b;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= i_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : MIPS EX-stage multiply/divide unit owning HI/LO; stalls while busy.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import mips_defs::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ALUOP_W-1:0] ALUOp_sig,
    input  logic [5:0]         funct,
    input  logic               issue,
    input  logic               flush,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    output logic               stall,
    output logic               busy,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               div_by_zero
);
    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_is_div, r_neg_q, r_neg_r, r_bzero;

    logic               w_recog, w_go, w_accept, w_signed, w_last, w_fix_we;
    logic [WIDTH-1:0]   w_rs_mag, w_rt_mag;
    logic [2*WIDTH-1:0] w_acc, w_prod;
    logic [WIDTH-1:0]   w_q, w_r, w_fix_hi, w_fix_lo;

    assign busy     = (r_state != ST_IDLE);
    assign w_recog  = issue & (ALUOp_sig == ALUOP_W'(ALUOP_RTYPE)) & is_recognised(funct);
    assign stall    = w_recog & busy;
    // Flush beats a same-cycle issue, so nothing is started or written.
    assign w_go     = w_recog & ~busy & ~flush;
    assign w_accept = w_go & is_muldiv(funct);
    assign w_signed = is_signed_op(funct);
    assign w_rs_mag = (w_signed & rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign w_rt_mag = (w_signed & rt_val[WIDTH-1]) ? -rt_val : rt_val;

    assign result_valid = w_go & ((funct == FUNCT_MFHI) | (funct == FUNCT_MFLO));
    assign result       = !result_valid ? '0 : ((funct == FUNCT_MFHI) ? r_hi : r_lo);

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_accept),
        .i_step   (r_state == ST_RUN),
        .i_is_div (r_is_div),
        .i_a      (w_rs_mag),
        .i_b      (w_rt_mag),
        .o_acc    (w_acc),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_is_div <= is_div_op(funct);
                r_neg_q  <= w_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                r_neg_r  <= w_signed & rs_val[WIDTH-1];
                r_bzero  <= (rt_val == '0);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fix_we    = 1'b0;
        div_by_zero = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush)       w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_FIX;
            end
            ST_FIX: begin
                w_state_nxt = ST_IDLE;
                if (!flush) begin
                    w_fix_we    = 1'b1;
                    div_by_zero = r_is_div & r_bzero;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sign correction of the magnitude result; divide-by-zero forces LO to all ones.
    always_comb begin
        w_prod   = r_neg_q ? -w_acc : w_acc;
        w_q      = w_acc[WIDTH-1:0];
        w_r      = w_acc[2*WIDTH-1:WIDTH];
        w_fix_hi = r_is_div ? (r_neg_r ? -w_r : w_r) : w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = r_is_div ? (r_bzero ? '1 : (r_neg_q ? -w_q : w_q)) : w_prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix_we) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else begin
            if (w_go && funct == FUNCT_MTHI) r_hi <= rs_val;
            if (w_go && funct == FUNCT_MTLO) r_lo <= rs_val;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire
